// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand sequencer: FSM state encoding,
// operation codes and the operand width used by the 4-bit adder datapath.
package calc_pkg;

  localparam int OPND_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button conditioner: 2-FF synchroniser, optional debounce filter and
// rising-edge detector producing a single-cycle pulse per accepted press.
// Optional feature macro: CALC_DEBOUNCE_EN (debounce filter compiled in).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic lvl_p2;
  logic lvl_prev;

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_lvl;

  // Accept a new level only after it has been seen DEBOUNCE_CYCLES times in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync_p1 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_cnt <= '0;
      db_lvl <= sync_p1;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign lvl_p2 = db_lvl;
`else
  assign lvl_p2 = sync_p1;
`endif

  // Previous accepted level, used to spot the low-to-high transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_prev <= 1'b0;
    end else begin
      lvl_prev <= lvl_p2;
    end
  end

  // Pulse is combinational so the FSM acts on the edge right after the level rises
  assign pulse = lvl_p2 & ~lvl_prev;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand sequencer feeding the external 4-bit ripple-carry adder. Captures
// operand A, then operand B with the operation, drives the adder for one cycle
// and latches its sum and status flags for the display stage.
// Optional feature macro: CALC_DEBOUNCE_EN (button debounce in button_conditioner).
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] SW,
  input  logic              Load,
  input  logic              Clear,
  input  logic              Op,
  output logic [OPND_W-1:0] A,
  output logic [OPND_W-1:0] B,
  output logic              Cin,
  input  logic [OPND_W-1:0] Sum,
  input  logic              Cout,
  output logic [OPND_W-1:0] Result,
  output logic              CarryOut,
  output logic              Borrow,
  output logic              Ovf,
  output logic              Valid,
  output logic [1:0]        State
);

  state_t            state;
  logic [OPND_W-1:0] a_reg;
  logic [OPND_W-1:0] b_reg;
  logic              op_reg;
  logic              load_p;
  logic              clear_p;

  // Signed overflow: both adder inputs share a sign that the sum does not
  function automatic logic ovf_calc(input logic [OPND_W-1:0] a_in,
                                    input logic [OPND_W-1:0] b_in,
                                    input logic [OPND_W-1:0] s_in);
    return (a_in[OPND_W-1] == b_in[OPND_W-1]) && (s_in[OPND_W-1] != a_in[OPND_W-1]);
  endfunction

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_cond (
    .clk  (clk),
    .rst  (rst),
    .btn  (Load),
    .pulse(load_p)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_cond (
    .clk  (clk),
    .rst  (rst),
    .btn  (Clear),
    .pulse(clear_p)
  );

  // Subtraction is A + ~B + 1, so the adder sees inverted B and Cin = 1
  assign A     = a_reg;
  assign B     = (op_reg == OP_SUB) ? ~b_reg : b_reg;
  assign Cin   = op_reg;
  assign State = state;

  // Operand capture / execute / hold sequence; Clear overrides Load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_A;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= OP_ADD;
      Result   <= '0;
      CarryOut <= 1'b0;
      Borrow   <= 1'b0;
      Ovf      <= 1'b0;
      Valid    <= 1'b0;
    end else if (clear_p) begin
      state    <= S_A;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= OP_ADD;
      Result   <= '0;
      CarryOut <= 1'b0;
      Borrow   <= 1'b0;
      Ovf      <= 1'b0;
      Valid    <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (load_p) begin
            a_reg <= SW;
            state <= S_B;
          end
        end
        S_B: begin
          if (load_p) begin
            b_reg  <= SW;
            op_reg <= Op;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The adder has had a full clock period to settle on A/B/Cin
          Result   <= Sum;
          CarryOut <= Cout;
          Borrow   <= op_reg & ~Cout;
          Ovf      <= ovf_calc(A, B, Sum);
          Valid    <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (load_p) begin
            a_reg <= SW;
            Valid <= 1'b0;
            state <= S_B;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Randomised scoreboard bench for calc_operand_sequencer with an ideal
// 4-bit adder attached to the A/B/Cin -> Sum/Cout path.
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] SW;
  logic       Load;
  logic       Clear;
  logic       Op;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic [3:0] Result;
  logic       CarryOut;
  logic       Borrow;
  logic       Ovf;
  logic       Valid;
  logic [1:0] State;

  logic [4:0] adder_out;

  typedef struct {
    int a_drv;
    int b_drv;
    int cin_drv;
    int res;
    int cout;
    int borrow;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  // Ideal adder standing in for the ripple-carry block
  assign adder_out = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
  assign Sum       = adder_out[3:0];
  assign Cout      = adder_out[4];

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .SW      (SW),
    .Load    (Load),
    .Clear   (Clear),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .Sum     (Sum),
    .Cout    (Cout),
    .Result  (Result),
    .CarryOut(CarryOut),
    .Borrow  (Borrow),
    .Ovf     (Ovf),
    .Valid   (Valid),
    .State   (State)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int sa, sb, sr;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    e.a_drv   = a;
    e.b_drv   = op ? (15 - b) : b;
    e.cin_drv = op;
    if (op != 0) begin
      e.res    = (a - b + 16) % 16;
      e.cout   = (a >= b) ? 1 : 0;
      e.borrow = (a < b) ? 1 : 0;
      sr       = sa - sb;
    end else begin
      e.res    = (a + b) % 16;
      e.cout   = (a + b > 15) ? 1 : 0;
      e.borrow = 0;
      sr       = sa + sb;
    end
    e.ovf = (sr > 7 || sr < -8) ? 1 : 0;
    return e;
  endfunction

  // Monitor: checks adder drive during execute and the latched result on Valid rise
  always @(negedge clk) begin
    if (!rst) begin
      if (State == 2'b10) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_without_request got state 2 expected no execute");
        end else begin
          check("drive_A", int'(A), exp_q[0].a_drv);
          check("drive_B", int'(B), exp_q[0].b_drv);
          check("drive_Cin", int'(Cin), exp_q[0].cin_drv);
        end
      end
      if (Valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_without_request got valid 1 expected 0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("Result", int'(Result), e.res);
          check("CarryOut", int'(CarryOut), e.cout);
          check("Borrow", int'(Borrow), e.borrow);
          check("Ovf", int'(Ovf), e.ovf);
          check("State_done", int'(State), 3);
        end
      end
    end
    valid_prev <= Valid;
  end

  task automatic press(input logic [3:0] sw, input logic op_in, input logic ld, input logic cl);
    @(negedge clk);
    SW    = sw;
    Op    = op_in;
    Load  = ld;
    Clear = cl;
    repeat (4) @(negedge clk);
    Load  = 1'b0;
    Clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic calc(input int a, input int b, input int op);
    press(4'(a), 1'b0, 1'b1, 1'b0);
    exp_q.push_back(model(a, b, op));
    press(4'(b), op[0], 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    SW    = 4'd0;
    Load  = 1'b0;
    Clear = 1'b0;
    Op    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_State", int'(State), 0);
    check("rst_A", int'(A), 0);
    check("rst_B", int'(B), 0);
    check("rst_Cin", int'(Cin), 0);
    check("rst_Result", int'(Result), 0);
    check("rst_Valid", int'(Valid), 0);
    check("rst_flags", int'({CarryOut, Borrow, Ovf}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    calc(5, 3, 0);
    check("after_5p3_Valid", int'(Valid), 1);
    calc(9, 9, 0);
    calc(3, 5, 1);
    calc(7, 2, 1);
    calc(0, 8, 1);
    calc(15, 1, 0);

    // Held Load yields a single capture: long press in S_DONE must stop at S_B
    @(negedge clk);
    SW   = 4'd4;
    Load = 1'b1;
    repeat (12) @(negedge clk);
    check("held_load_State", int'(State), 1);
    check("held_load_A", int'(A), 4);
    check("held_load_Valid", int'(Valid), 0);
    Load = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(model(4, 6, 0));
    press(4'd6, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Randomised calculations
    for (int i = 0; i < 24; i++) begin
      calc(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end

    // Clear while waiting for B
    press(4'b0110, 1'b0, 1'b1, 1'b0);
    check("pre_clear_State", int'(State), 1);
    check("pre_clear_A", int'(A), 6);
    press(4'd0, 1'b0, 1'b0, 1'b1);
    check("clear_State", int'(State), 0);
    check("clear_A", int'(A), 0);
    check("clear_Valid", int'(Valid), 0);
    press(4'd11, 1'b0, 1'b1, 1'b0);
    check("after_clear_A", int'(A), 11);
    exp_q.push_back(model(11, 12, 1));
    press(4'd12, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Load and Clear together in S_DONE: Clear wins
    check("pre_both_State", int'(State), 3);
    press(4'd9, 1'b0, 1'b1, 1'b1);
    check("both_State", int'(State), 0);
    check("both_Valid", int'(Valid), 0);
    check("both_Result", int'(Result), 0);
    check("both_A", int'(A), 0);

    // Reset mid-operation drops the captured operand
    press(4'd13, 1'b0, 1'b1, 1'b0);
    check("pre_rst_A", int'(A), 13);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_State", int'(State), 0);
    check("midrst_A", int'(A), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    calc(6, 7, 0);

    repeat (5) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
